// File: rtl/ring_anim_sequencer.sv
// ring_anim_sequencer
// -------------------
// Per-frame animation controller for the concentric-rings pixel datapath.
// It finds the start of each frame from the sync generator position and
// brings the user controls into the clock domain. A run/pause/turn state
// machine then produces a ring phase offset and an effective direction. Both
// are updated only on the frame tick, so they stay stable for a whole frame.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   hpos, vpos   current pixel / line position from the sync generator
//   speed_in     0 = slow (STEP), 1 = fast (2*STEP); asynchronous
//   dir_in       0 = outward, 1 = inward; asynchronous
//   pause_in     1 = freeze animation; asynchronous
//   auto_in      1 = auto ping-pong (periodic reversal); asynchronous
//   anim_offset  ring phase offset (8-bit, wraps modulo 256)
//   dir_out      effective direction = dir ^ (auto & flip)
//   frame_tick   one-cycle pulse at frame start
//   state        00 RUN, 01 PAUSED, 10 TURN
//
// Optional build macro: RING_ANIM_EASE_EN. When it is defined, the step is
// forced to 1 during the last four RUN frames before an auto turn, so the
// rings slow down before each reversal.

module ring_anim_sequencer #(
  parameter int PERIOD_FRAMES = 120,  // RUN frames before an auto turn (>= 5)
  parameter int TURN_FRAMES   = 8,    // frames held in TURN before the flip (>= 1)
  parameter int STEP          = 1     // base phase increment per frame
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       speed_in,
  input  logic       dir_in,
  input  logic       pause_in,
  input  logic       auto_in,
  output logic [7:0] anim_offset,
  output logic       dir_out,
  output logic       frame_tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_TURN   = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  // The counter is shared by RUN (period count) and TURN (hold count).
  localparam int CNT_MAX = (PERIOD_FRAMES > TURN_FRAMES) ? PERIOD_FRAMES : TURN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_FRAMES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_FRAMES - 1);
  localparam logic [7:0] STEP_SLOW = 8'(STEP);
  localparam logic [7:0] STEP_FAST = 8'(2 * STEP);
`ifdef RING_ANIM_EASE_EN
  localparam logic [CNT_W-1:0] EASE_FROM = CNT_W'(PERIOD_FRAMES - 4);
`endif

  // Control synchronisers: bit order {auto, pause, dir, speed}.
  logic [3:0] ctrl_async;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic       speed_s, dir_s, pause_s, auto_s;

  assign ctrl_async = {auto_in, pause_in, dir_in, speed_in};
  assign speed_s    = sync2_reg[0];
  assign dir_s      = sync2_reg[1];
  assign pause_s    = sync2_reg[2];
  assign auto_s     = sync2_reg[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ctrl_async;
      sync2_reg <= sync1_reg;
    end
  end

  // Frame start detection. The edge detect keeps a stalled generator that
  // sits at (0,0) from producing more than one tick.
  logic sof;
  logic sof_prev_reg;
  logic tick;

  assign sof  = (hpos == 10'd0) && (vpos == 10'd0);
  assign tick = sof && !sof_prev_reg;

  // Animation state.
  state_t           state_reg, state_next;
  logic [7:0]       offset_reg, offset_next;
  logic             flip_reg, flip_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ret_turn_reg, ret_turn_next;  // PAUSED was entered from TURN
  logic             dir_out_reg, dir_out_next;
  logic             frame_tick_reg;
  logic [7:0]       step;
  logic             eff_dir;

  always_comb begin
    state_next    = state_reg;
    offset_next   = offset_reg;
    flip_next     = flip_reg;
    cnt_next      = cnt_reg;
    ret_turn_next = ret_turn_reg;

    step = speed_s ? STEP_FAST : STEP_SLOW;
`ifdef RING_ANIM_EASE_EN
    if ((state_reg == ST_RUN) && auto_s && (cnt_reg >= EASE_FROM)) begin
      step = 8'd1;
    end
`endif
    // Direction used for this frame's offset move, before any flip change.
    eff_dir = dir_s ^ (auto_s & flip_reg);

    case (state_reg)
      ST_RUN: begin
        if (pause_s) begin
          // Entering PAUSED skips the offset move; the period count is
          // only meaningful while auto is on.
          state_next    = ST_PAUSED;
          ret_turn_next = 1'b0;
          if (!auto_s) begin
            cnt_next = '0;
          end
        end else begin
          offset_next = eff_dir ? (offset_reg - step) : (offset_reg + step);
          if (auto_s && (cnt_reg == PERIOD_LAST)) begin
            state_next = ST_TURN;
            cnt_next   = '0;
          end else if (auto_s) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            cnt_next = '0;
          end
        end
      end

      ST_PAUSED: begin
        if (!pause_s) begin
          state_next = ret_turn_reg ? ST_TURN : ST_RUN;
        end
      end

      ST_TURN: begin
        // Pause beats turn completion, and the hold count survives the pause.
        if (pause_s) begin
          state_next    = ST_PAUSED;
          ret_turn_next = 1'b1;
        end else if (!auto_s) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (cnt_reg == TURN_LAST) begin
          flip_next  = ~flip_reg;
          cnt_next   = '0;
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase

    // The new flip shows up on dir_out on the same tick that it toggles.
    dir_out_next = dir_s ^ (auto_s & flip_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_prev_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
      state_reg      <= ST_RUN;
      offset_reg     <= 8'd0;
      flip_reg       <= 1'b0;
      cnt_reg        <= '0;
      ret_turn_reg   <= 1'b0;
      dir_out_reg    <= 1'b0;
    end else begin
      sof_prev_reg   <= sof;
      frame_tick_reg <= tick;
      if (tick) begin
        state_reg    <= state_next;
        offset_reg   <= offset_next;
        flip_reg     <= flip_next;
        cnt_reg      <= cnt_next;
        ret_turn_reg <= ret_turn_next;
        dir_out_reg  <= dir_out_next;
      end
    end
  end

  assign anim_offset = offset_reg;
  assign dir_out     = dir_out_reg;
  assign frame_tick  = frame_tick_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_ring_anim_sequencer.sv
// Testbench for ring_anim_sequencer. It applies directed frames and then
// randomized frames. A frame-level reference model, written from the
// behaviour rules, supplies the expected offset, direction and state.
// The DUT is built with PERIOD_FRAMES=6, TURN_FRAMES=2 and STEP=1.

module tb_ring_anim_sequencer;
  localparam int P    = 6;
  localparam int T    = 2;
  localparam int STEP = 1;
  localparam int S_RUN    = 0;
  localparam int S_PAUSED = 1;
  localparam int S_TURN   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       speed_in, dir_in, pause_in, auto_in;
  logic [7:0] anim_offset;
  logic       dir_out, frame_tick;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_count = 0;

  // Reference model state (frame level)
  int m_offset, m_flip, m_state, m_cnt, m_ret, m_dir_out;

  ring_anim_sequencer #(.PERIOD_FRAMES(P), .TURN_FRAMES(T), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .speed_in(speed_in), .dir_in(dir_in), .pause_in(pause_in), .auto_in(auto_in),
    .anim_offset(anim_offset), .dir_out(dir_out), .frame_tick(frame_tick), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".offset"}, 32'(anim_offset), m_offset);
    check({tag, ".dir_out"}, 32'(dir_out), m_dir_out);
    check({tag, ".state"}, 32'(state), m_state);
  endtask

  task automatic model_reset();
    m_offset = 0; m_flip = 0; m_state = S_RUN; m_cnt = 0; m_ret = 0; m_dir_out = 0;
  endtask

  // One frame tick applied with the current (stable) control values.
  task automatic model_tick();
    int step, eff, sp, dr, pz, au;
    sp = int'(speed_in); dr = int'(dir_in); pz = int'(pause_in); au = int'(auto_in);
    step = (sp != 0 ? 2 * STEP : STEP) % 256;
    if (m_state == S_RUN) begin
      if (pz != 0) begin
        m_state = S_PAUSED;
        m_ret = 0;
        if (au == 0) m_cnt = 0;
      end else begin
`ifdef RING_ANIM_EASE_EN
        if (au != 0 && m_cnt >= P - 4) step = 1;
`endif
        eff = dr ^ (au & m_flip);
        m_offset = (m_offset + (eff != 0 ? 256 - step : step)) % 256;
        if (au != 0 && m_cnt == P - 1) begin
          m_state = S_TURN;
          m_cnt = 0;
        end else begin
          m_cnt = (au != 0) ? m_cnt + 1 : 0;
        end
      end
    end else if (m_state == S_PAUSED) begin
      if (pz == 0) m_state = (m_ret != 0) ? S_TURN : S_RUN;
    end else begin
      if (pz != 0) begin
        m_state = S_PAUSED;
        m_ret = 1;
      end else if (au == 0) begin
        m_state = S_RUN;
        m_cnt = 0;
      end else if (m_cnt == T - 1) begin
        m_flip = 1 - m_flip;
        m_cnt = 0;
        m_state = S_RUN;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_dir_out = dr ^ (au & m_flip);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hpos = 10'(40 + i);
      vpos = 10'd9;
    end
  endtask

  // A short frame: lead-in, (0,0) held for 'stall' cycles, then a tail.
  task automatic do_frame(input int stall);
    tick_count = 0;
    idle(4);
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd0;
    model_tick();
    @(negedge clk);
    check("frame_tick", 32'(frame_tick), 1);
    check_outputs("at_tick");
    for (int i = 1; i < stall; i++) @(negedge clk);
    idle(8);
    check("ticks_per_frame", tick_count, 1);
    check_outputs("frame_end");
    $display("frame: ctl s%0d d%0d p%0d a%0d -> offset %0d dir_out %0d state %0d",
             speed_in, dir_in, pause_in, auto_in, anim_offset, dir_out, state);
  endtask

  initial begin
    int found;
    reset = 1'b1;
    hpos = 10'd5; vpos = 10'd5;
    speed_in = 1'b0; dir_in = 1'b0; pause_in = 1'b0; auto_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.frame_tick", 32'(frame_tick), 0);
    check_outputs("reset");
    reset = 1'b0;

    // Three slow outward frames: 1, 2, 3.
    do_frame(1);
    check("first_offset", 32'(anim_offset), 1);
    do_frame(1);
    do_frame(2);
    check("third_offset", 32'(anim_offset), 3);

    // Wrap down to 254, then fast up through 0 and back down through 255.
    dir_in = 1'b1;
    repeat (5) do_frame(1);
    check("down_to_254", 32'(anim_offset), 254);
    speed_in = 1'b1; dir_in = 1'b0;
    do_frame(1);
    check("wrap_up", 32'(anim_offset), 0);
    do_frame(1);
    speed_in = 1'b0; dir_in = 1'b1;
    do_frame(1);
    speed_in = 1'b1;
    do_frame(1);
    check("wrap_down", 32'(anim_offset), 255);

    // Pause asserted mid-frame: nothing changes until the next tick.
    speed_in = 1'b0; dir_in = 1'b0;
    do_frame(1);
    pause_in = 1'b1;
    idle(10);
    check_outputs("mid_frame_pause");
    repeat (5) do_frame(1);
    check("paused_state", 32'(state), 1);
    pause_in = 1'b0;
    do_frame(1);
    do_frame(1);

    // Auto ping-pong: 6 RUN, 2 TURN, flipped, 6 RUN, 2 TURN, back.
    auto_in = 1'b1;
    for (int f = 1; f <= 16; f++) begin
      do_frame(1);
      if (f == 7)  check("turn_state", 32'(state), 2);
      if (f == 8)  check("flipped_dir", 32'(dir_out), 1);
      if (f == 16) check("unflipped_dir", 32'(dir_out), 0);
    end

    // Pause on the very tick the turn would complete.
    found = 0;
    for (int f = 0; f < 20 && found == 0; f++) begin
      if (m_state == S_TURN && m_cnt == T - 1) found = 1;
      else do_frame(1);
    end
    check("reach_turn_end", found, 1);
    pause_in = 1'b1;
    do_frame(1);
    check("pause_beats_turn", 32'(state), 1);
    pause_in = 1'b0;
    do_frame(1);
    check("resume_turn", 32'(state), 2);
    do_frame(1);
    check("turn_completes", 32'(state), 0);

    // Asynchronous reset in the middle of a TURN frame.
    found = 0;
    for (int f = 0; f < 20 && found == 0; f++) begin
      if (m_state == S_TURN) found = 1;
      else do_frame(1);
    end
    check("reach_turn", found, 1);
    idle(3);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset.frame_tick", 32'(frame_tick), 0);
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    do_frame(1);

    // Randomized frames against the model.
    for (int f = 0; f < 200; f++) begin
      speed_in = 1'($urandom % 2);
      if ($urandom % 10 == 0) dir_in = ~dir_in;
      pause_in = ($urandom % 8 == 0);
      auto_in  = ($urandom % 6 != 0);
      do_frame(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
